// File: rtl/id_exe_vpipe.sv
// ID->EXE vector pipeline register: 2-entry elastic buffer (main + skid) with
// lane masking on capture, flush, occupancy and saturating stall counter.
module id_exe_vpipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RD_W  = 4,
  parameter int unsigned ALU_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic [LANES-1:0]       lane_mask_in,
  input  logic [LANES*WIDTH-1:0] vopa_in,
  input  logic [LANES*WIDTH-1:0] vopb_in,
  input  logic [WIDTH-1:0]       op1_in,
  input  logic [WIDTH-1:0]       op2_in,
  input  logic [RD_W-1:0]        rd_in,
  input  logic [ALU_W-1:0]       aluControl_in,
  input  logic [4:0]             ctrl_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] vopa_out,
  output logic [LANES*WIDTH-1:0] vopb_out,
  output logic [WIDTH-1:0]       op1_out,
  output logic [WIDTH-1:0]       op2_out,
  output logic [RD_W-1:0]        rd_out,
  output logic [ALU_W-1:0]       aluControl_out,
  output logic [4:0]             ctrl_out,
  output logic [LANES-1:0]       lane_mask_out,
  output logic [1:0]             occupancy,
  output logic [15:0]            stall_count
);

  localparam int unsigned VW     = LANES * WIDTH;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned OCC_W  = 2;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic [LANES-1:0]  mask;
    logic [VW-1:0]     vopa;
    logic [VW-1:0]     vopb;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [RD_W-1:0]   rd;
    logic [ALU_W-1:0]  alu;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t   state, state_nxt;
  payload_t main_q, skid_q, in_pl_c;
  logic     push_c, pop_c;
  logic     load_main_c, load_skid_c, skid_to_main_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Incoming payload with inactive lanes zeroed.
  always_comb begin
    in_pl_c      = '0;
    in_pl_c.mask = lane_mask_in;
    in_pl_c.op1  = op1_in;
    in_pl_c.op2  = op2_in;
    in_pl_c.rd   = rd_in;
    in_pl_c.alu  = aluControl_in;
    in_pl_c.ctrl = ctrl_in;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_mask_in[i]) begin
        in_pl_c.vopa[i*WIDTH +: WIDTH] = vopa_in[i*WIDTH +: WIDTH];
        in_pl_c.vopb[i*WIDTH +: WIDTH] = vopb_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and entry movement; flush overrides every transfer.
  always_comb begin
    state_nxt      = state;
    load_main_c    = 1'b0;
    load_skid_c    = 1'b0;
    skid_to_main_c = 1'b0;
    case (state)
      EMPTY: begin
        if (push_c) begin
          state_nxt   = ONE;
          load_main_c = 1'b1;
        end
      end
      ONE: begin
        if (push_c && pop_c) begin
          load_main_c = 1'b1;
        end else if (push_c) begin
          state_nxt   = FULL;
          load_skid_c = 1'b1;
        end else if (pop_c) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop_c) begin
          state_nxt      = ONE;
          skid_to_main_c = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_c    = 1'b0;
      load_skid_c    = 1'b0;
      skid_to_main_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      occupancy   <= '0;
      main_q      <= '0;
      skid_q      <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != FULL);
      out_valid <= (state_nxt != EMPTY);
      occupancy <= OCC_W'(state_nxt);
      if (load_main_c) begin
        main_q <= in_pl_c;
      end else if (skid_to_main_c) begin
        main_q <= skid_q;
      end
      if (load_skid_c) begin
        skid_q <= in_pl_c;
      end
      // Control bits are suppressed while no instruction is presented.
      if (state_nxt == EMPTY) begin
        main_q.ctrl <= '0;
      end
      if (out_valid && !out_ready && (stall_count != STALL_MAX)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  assign vopa_out       = main_q.vopa;
  assign vopb_out       = main_q.vopb;
  assign op1_out        = main_q.op1;
  assign op2_out        = main_q.op2;
  assign rd_out         = main_q.rd;
  assign aluControl_out = main_q.alu;
  assign ctrl_out       = main_q.ctrl;
  assign lane_mask_out  = main_q.mask;

endmodule

// File: doc/id_exe_vpipe.md
ID_EXE_VPIPE -- requirements
Module: id_exe_vpipe

Interface
REQ-001 Parameter LANES, default 4, number of vector lanes (1..8).
REQ-002 Parameter WIDTH, default 16, bits per lane operand and per scalar operand.
REQ-003 Parameter RD_W, default 4, destination-register index width.
REQ-004 Parameter ALU_W, default 4, ALU control width.
REQ-005 clk  in  1  system clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-007 in_valid  in  1  ID stage presents a valid decoded instruction.
REQ-008 in_ready  out  1  block accepts the ID payload this cycle.
REQ-009 flush  in  1  discard all held and incoming instructions (branch mispredict).
REQ-010 lane_mask_in  in  LANES  per-lane enable; 0 = lane inactive.
REQ-011 vopa_in / vopb_in  in  LANES*WIDTH each  vector operands A/B, lane i at bits [i*WIDTH +: WIDTH].
REQ-012 op1_in / op2_in  in  WIDTH each  scalar operands.
REQ-013 rd_in  in  RD_W  destination register; aluControl_in  in  ALU_W  ALU control.
REQ-014 ctrl_in  in  5  {updateCount, resultSrc, branch, memWrite, regWrite}, bit 0 = regWrite.
REQ-015 out_valid  out  1  EXE payload valid; out_ready  in  1  EXE consumes payload this cycle.
REQ-016 vopa_out, vopb_out, op1_out, op2_out, rd_out, aluControl_out, ctrl_out, lane_mask_out  out  widths as inputs  EXE payload.
REQ-017 occupancy  out  2  entries held (0, 1 or 2).
REQ-018 stall_count  out  16  saturating count of back-pressure cycles.

Function
REQ-019 Block SHALL be a 2-entry elastic register (main + skid) with states EMPTY, ONE, FULL; payload order SHALL be preserved.
REQ-020 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven only from registered state (no combinational path from out_ready).
REQ-022 EMPTY: push -> ONE (payload into main).
REQ-023 ONE: pop only -> EMPTY; push only -> FULL (payload into skid); push & pop -> ONE (main replaced by new payload).
REQ-024 FULL: pop -> ONE (skid moves to main); no pop -> FULL, contents held.
REQ-025 out_valid SHALL be 1 exactly in ONE and FULL; output payload SHALL always be the main entry.
REQ-026 Latency SHALL be one cycle: payload pushed at edge N is on outputs with out_valid=1 after edge N when block was EMPTY.
REQ-027 On capture, lanes with lane_mask_in[i]=0 SHALL store 0 in vopa/vopb lane i; lane_mask_out carries captured mask.
REQ-028 ctrl_out SHALL be forced to 0 whenever out_valid=0; other payload outputs hold last main contents.
REQ-029 flush=1 SHALL move state to EMPTY at next edge, overriding any same-cycle push and pop; in_ready remains per current state that cycle but pushed data SHALL be discarded.
REQ-030 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-031 stall_count SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturating at 16'hFFFF; never wraps; not cleared by flush.

Reset
REQ-032 When reset=0 at a rising edge, state SHALL become EMPTY, all payload registers 0, stall_count 0, regardless of flush, in_valid, out_ready.
REQ-033 After reset: out_valid=0, in_ready=1, occupancy=0, all payload outputs and ctrl_out 0.
REQ-034 Reset mid-operation (ONE or FULL) SHALL discard held instructions with no output handshake.

Verification
REQ-035 LANES=4: reset, push op1=16'h1234, rd=3, ctrl=5'b00001, out_ready=1 -> next cycle out_valid=1, op1_out=16'h1234, rd_out=3, occupancy=1.
REQ-036 out_ready=0, push A then B -> occupancy=2, in_ready=0, stall_count increments per cycle; raise out_ready -> A then B appear on consecutive cycles, then out_valid=0.
REQ-037 lane_mask_in=4'b0101, vopa_in lanes all 16'hFFFF -> vopa_out lanes 1 and 3 = 0, lanes 0 and 2 = 16'hFFFF.
REQ-038 FULL with flush=1 and simultaneous in_valid=1 -> next cycle occupancy=0, out_valid=0, ctrl_out=0, in_ready=1.
REQ-039 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_count=16'hFFFF and stays there.
REQ-040 reset=0 while FULL -> next cycle all outputs at reset values, stall_count=0.
